// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - decode-stage hazard, flush and operand-forwarding controller; optional macro HAZ_FWD_EN
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FLUSH_CYCLES   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_rd_wen,
  input  logic                      id_is_load,
  input  logic                      ex_redirect,
  input  logic                      mem_busy,
  output logic                      pc_en,
  output logic                      ifid_hold,
  output logic                      ifid_flush,
  output logic                      idex_bubble,
  output logic                      pipe_hold,
  output logic [1:0]                fwd_a,
  output logic [1:0]                fwd_b,
  output logic                      hazard_stall
);

  // Shadow record of one in-flight instruction; is_load is only kept for EX,
  // the only stage whose load status matters.
  typedef struct packed {
    logic                      v;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      wen;
  } ent_t;

  ent_t       r_e;
  ent_t       r_m;
  ent_t       w_dec;
  logic [2:0] r_cnt;
  logic       r_init;

  logic w_hit_e_a, w_hit_e_b, w_hit_m_a, w_hit_m_b;
  logic w_hazard, w_busy, w_redir, w_redir_load, w_stall, w_enter;

`ifdef HAZ_FWD_EN
  logic       r_e_ld;
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;
  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;
`else
  ent_t r_w;
  logic w_hit_w_a, w_hit_w_b;
  logic w_unused_ok;
`endif

  // A stage feeds a source when it is a real producer of a nonzero register
  // that the decode instruction actually reads.
  function automatic logic hit(input ent_t e, input logic [REG_ADDR_WIDTH-1:0] src,
                               input logic used);
    return used & e.v & e.wen & (e.rd != '0) & (e.rd == src);
  endfunction

  assign w_hit_e_a = hit(r_e, id_rs1, id_rs1_used);
  assign w_hit_e_b = hit(r_e, id_rs2, id_rs2_used);
  assign w_hit_m_a = hit(r_m, id_rs1, id_rs1_used);
  assign w_hit_m_b = hit(r_m, id_rs2, id_rs2_used);

`ifdef HAZ_FWD_EN
  // Only a load still in EX cannot be forwarded in time.
  assign w_hazard = id_valid & r_e_ld & (w_hit_e_a | w_hit_e_b);
`else
  // Without bypassing, decode must wait until the producer has left WB,
  // since the regfile write lands on the same edge decode reads old data.
  assign w_hit_w_a   = hit(r_w, id_rs1, id_rs1_used);
  assign w_hit_w_b   = hit(r_w, id_rs2, id_rs2_used);
  assign w_hazard    = id_valid & (w_hit_e_a | w_hit_e_b | w_hit_m_a | w_hit_m_b |
                                   w_hit_w_a | w_hit_w_b);
  assign w_unused_ok = id_is_load;
`endif

  // r_init masks every control during reset and the first cycle after it.
  assign w_busy       = mem_busy & ~r_init;
  assign w_redir_load = ex_redirect & ~r_init;
  assign w_redir      = (ex_redirect | (r_cnt != 3'd0)) & ~r_init;
  assign w_stall      = w_hazard & ~r_init;

  // Pipeline control outputs, priority busy > redirect > stall > advance.
  always_comb begin
    pc_en        = 1'b1;
    ifid_hold    = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    pipe_hold    = 1'b0;
    hazard_stall = 1'b0;
    if (w_busy) begin
      pc_en        = 1'b0;
      ifid_hold    = 1'b1;
      pipe_hold    = 1'b1;
      hazard_stall = w_stall;
    end else if (w_redir) begin
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
    end else if (w_stall) begin
      pc_en        = 1'b0;
      ifid_hold    = 1'b1;
      idex_bubble  = 1'b1;
      hazard_stall = 1'b1;
    end
  end

  assign w_enter = id_valid & ~idex_bubble;
  assign w_dec   = {w_enter, id_rd, id_rd_wen};

  // Reset mask: set asynchronously, released by the first clock after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_init <= 1'b1;
    else     r_init <= 1'b0;
  end

  // Shadow pipeline advances on every edge the memory is not stalling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e <= '0;
      r_m <= '0;
    end else if (!w_busy) begin
      r_m <= r_e;
      r_e <= w_dec;
    end
  end

  // Flush counter: a redirect (re)loads it, otherwise it drains to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 3'd0;
    end else if (!w_busy) begin
      if (w_redir_load)        r_cnt <= 3'(FLUSH_CYCLES - 1);
      else if (r_cnt != 3'd0)  r_cnt <= r_cnt - 3'd1;
    end
  end

`ifdef HAZ_FWD_EN
  // Youngest producer wins; a bubble entering EX gets no bypass.
  assign w_sel_a = !w_enter ? 2'b00 : w_hit_e_a ? 2'b01 : w_hit_m_a ? 2'b10 : 2'b00;
  assign w_sel_b = !w_enter ? 2'b00 : w_hit_e_b ? 2'b01 : w_hit_m_b ? 2'b10 : 2'b00;

  // Forward selects and EX load flag move with the instruction into EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e_ld  <= 1'b0;
      r_fwd_a <= 2'b00;
      r_fwd_b <= 2'b00;
    end else if (!w_busy) begin
      r_e_ld  <= w_enter & id_is_load;
      r_fwd_a <= w_sel_a;
      r_fwd_b <= w_sel_b;
    end
  end

  assign fwd_a = r_fwd_a;
  assign fwd_b = r_fwd_b;
`else
  // WB shadow entry, needed only for the full interlock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_w <= '0;
    else if (!w_busy)   r_w <= r_m;
  end

  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

endmodule
